// File: rtl/case_1_mul_share_arb.sv
// Round-robin arbiter sharing one signed DIN0_W x DIN1_W multiplier; operand and product registered.
// Define CASE_1_MUL_ARB_STATS_EN to make stat_grants count accepted requests (tied to 0 otherwise).
module case_1_mul_share_arb #(
  parameter int N_REQ  = 4,
  parameter int ID_W   = 2,
  parameter int DIN0_W = 14,
  parameter int DIN1_W = 12,
  parameter int DOUT_W = 26
) (
  input  logic                       ap_clk,
  input  logic                       ap_rst_n,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DIN0_W-1:0]    req_din0,
  input  logic [N_REQ*DIN1_W-1:0]    req_din1,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic signed [DOUT_W-1:0]   rsp_dout,
  output logic [ID_W-1:0]            rsp_id,
  output logic [31:0]                stat_grants
);

  logic                     a_valid_r;
  logic [DIN0_W-1:0]        a_din0_r;
  logic [DIN1_W-1:0]        a_din1_r;
  logic [ID_W-1:0]          a_id_r;
  logic [ID_W-1:0]          rr_ptr_r;
  logic                     rsp_valid_r;
  logic [DOUT_W-1:0]        rsp_dout_r;
  logic [ID_W-1:0]          rsp_id_r;

  logic                     b_en_s;
  logic                     a_load_ok_s;
  logic                     a_adv_s;
  logic                     gnt_any_s;
  logic                     accept_s;
  logic [ID_W-1:0]          gnt_idx_s;
  logic [ID_W-1:0]          rr_next_s;
  logic [DIN0_W-1:0]        gnt_din0_s;
  logic [DIN1_W-1:0]        gnt_din1_s;
  logic [DOUT_W-1:0]        op0_ext_s;
  logic [DOUT_W-1:0]        op1_ext_s;
  logic [DOUT_W-1:0]        prod_s;
  int                       scan_idx_s;

  assign b_en_s      = !rsp_valid_r || rsp_ready;
  assign a_load_ok_s = !a_valid_r || b_en_s;
  assign a_adv_s     = a_valid_r && b_en_s;
  assign accept_s    = ap_rst_n && gnt_any_s && a_load_ok_s;
  assign rr_next_s   = (gnt_idx_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}} : (gnt_idx_s + ID_W'(1));

  // Full-precision product: sign-extend both operands to DOUT_W, the low DOUT_W bits are exact.
  assign op0_ext_s = {{(DOUT_W - DIN0_W){a_din0_r[DIN0_W-1]}}, a_din0_r};
  assign op1_ext_s = {{(DOUT_W - DIN1_W){a_din1_r[DIN1_W-1]}}, a_din1_r};
  assign prod_s    = op0_ext_s * op1_ext_s;

  assign rsp_valid = rsp_valid_r;
  assign rsp_dout  = rsp_dout_r;
  assign rsp_id    = rsp_id_r;

  // Circular search from rr_ptr for the first valid requester and select its operands.
  always_comb begin
    scan_idx_s = 0;
    gnt_any_s  = 1'b0;
    gnt_idx_s  = {ID_W{1'b0}};
    gnt_din0_s = {DIN0_W{1'b0}};
    gnt_din1_s = {DIN1_W{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      scan_idx_s = int'(rr_ptr_r) + i;
      if (scan_idx_s >= N_REQ) begin
        scan_idx_s = scan_idx_s - N_REQ;
      end else begin
        scan_idx_s = scan_idx_s;
      end
      if (!gnt_any_s && req_valid[scan_idx_s]) begin
        gnt_any_s  = 1'b1;
        gnt_idx_s  = ID_W'(scan_idx_s);
        gnt_din0_s = req_din0[scan_idx_s*DIN0_W +: DIN0_W];
        gnt_din1_s = req_din1[scan_idx_s*DIN1_W +: DIN1_W];
      end else begin
        gnt_any_s = gnt_any_s;
      end
    end
  end

  // One-hot ready to the granted requester whenever stage A can take a new operand pair.
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if (accept_s && (int'(gnt_idx_s) == i)) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Stage A operand register and round-robin pointer.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      a_valid_r <= 1'b0;
      a_din0_r  <= {DIN0_W{1'b0}};
      a_din1_r  <= {DIN1_W{1'b0}};
      a_id_r    <= {ID_W{1'b0}};
      rr_ptr_r  <= {ID_W{1'b0}};
    end else if (accept_s) begin
      a_valid_r <= 1'b1;
      a_din0_r  <= gnt_din0_s;
      a_din1_r  <= gnt_din1_s;
      a_id_r    <= gnt_idx_s;
      rr_ptr_r  <= rr_next_s;
    end else if (a_adv_s) begin
      a_valid_r <= 1'b0;
    end else begin
      a_valid_r <= a_valid_r;
    end
  end

  // Stage B product register; holds under backpressure, empties when A has nothing to give.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rsp_valid_r <= 1'b0;
      rsp_dout_r  <= {DOUT_W{1'b0}};
      rsp_id_r    <= {ID_W{1'b0}};
    end else if (b_en_s) begin
      if (a_valid_r) begin
        rsp_valid_r <= 1'b1;
        rsp_dout_r  <= prod_s;
        rsp_id_r    <= a_id_r;
      end else begin
        rsp_valid_r <= 1'b0;
      end
    end else begin
      rsp_valid_r <= rsp_valid_r;
    end
  end

`ifdef CASE_1_MUL_ARB_STATS_EN
  logic [31:0] stat_cnt_r;

  // Accepted-request counter, wraps naturally at 32 bits.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_cnt_r <= 32'd0;
    end else if (accept_s) begin
      stat_cnt_r <= stat_cnt_r + 32'd1;
    end else begin
      stat_cnt_r <= stat_cnt_r;
    end
  end

  assign stat_grants = stat_cnt_r;
`else
  assign stat_grants = 32'd0;
`endif

endmodule

// File: tb/tb_case_1_mul_share_arb.sv
// Scoreboard bench for case_1_mul_share_arb: directed requests push expected {id, product}; a monitor pops on each handshake.
module tb_case_1_mul_share_arb;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int W0 = 14;
  localparam int W1 = 12;
  localparam int WO = 26;

  localparam int P0 = 300;
  localparam int P1 = -350;
  localparam int P2 = -16775168;
  localparam int P3 = 1;

  logic                     ap_clk = 1'b0;
  logic                     ap_rst_n;
  logic [N-1:0]             req_valid;
  logic [N-1:0]             req_ready;
  logic [N*W0-1:0]          req_din0;
  logic [N*W1-1:0]          req_din1;
  logic                     rsp_valid;
  logic                     rsp_ready;
  logic signed [WO-1:0]     rsp_dout;
  logic [IW-1:0]            rsp_id;
  logic [31:0]              stat_grants;

  typedef struct packed {
    logic [IW-1:0]        id;
    logic signed [WO-1:0] dout;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   errors = 0;
  int   checks = 0;

  case_1_mul_share_arb #(.N_REQ(N), .ID_W(IW), .DIN0_W(W0), .DIN1_W(W1), .DOUT_W(WO)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_dout(rsp_dout), .rsp_id(rsp_id),
    .stat_grants(stat_grants)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic check_dout(input string name, input logic signed [WO-1:0] act, input logic signed [WO-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, req);
    end
  endtask

  task automatic set_req(input int i, input int a, input int b);
    req_din0[i*W0 +: W0] = W0'(a);
    req_din1[i*W1 +: W1] = W1'(b);
  endtask

  task automatic push_exp(input int id, input int p);
    exp_t e;
    e.id   = IW'(id);
    e.dout = WO'(p);
    exp_q.push_back(e);
  endtask

  task automatic load_std_data();
    set_req(0, 100, 3);
    set_req(1, -50, 7);
    set_req(2, 8191, -2048);
    set_req(3, -1, -1);
  endtask

  task automatic do_reset();
    ap_rst_n  = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 50 && !done; c++) begin
      @(posedge ap_clk);
      #2;
      if (exp_q.size() == 0 && !rsp_valid) done = 1'b1;
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Monitor: every completed response handshake is compared with the oldest expectation.
  always @(negedge ap_clk) begin
    if (ap_rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id=%0d dout=%0d required no response", rsp_id, rsp_dout);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        check_dout("rsp_dout", rsp_dout, mon_e.dout);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    int acc;
    int stale;
    req_din0 = '0;
    req_din1 = '0;
    do_reset();

    // Reset state, with requests pending during reset
    req_valid = 4'b1111;
    ap_rst_n  = 1'b0;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    ap_rst_n  = 1'b1;
    req_valid = 4'b0000;
    #1;
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_id", 32'(rsp_id), 32'd0);
    check_dout("rst_rsp_dout", rsp_dout, WO'(0));
    check("rst_stat", stat_grants, 32'd0);

    // Single request from requester 2
    @(posedge ap_clk); #1;
    set_req(2, -8192, -2048);
    req_valid = 4'b0100;
    push_exp(2, 16777216);
    @(negedge ap_clk);
    check("t2_ready", 32'(req_ready), 32'h4);
    @(posedge ap_clk); #1 req_valid = 4'b0000;
    @(negedge ap_clk);
    check("t2_lat_a", 32'(rsp_valid), 32'd0);
    @(negedge ap_clk);
    check("t2_lat_b", 32'(rsp_valid), 32'd1);
    wait_idle("t2_drain");

    // Extremes back-to-back on requester 0
    @(posedge ap_clk); #1;
    set_req(0, 8191, 2047);
    req_valid = 4'b0001;
    push_exp(0, 16766977);
    push_exp(0, -16769024);
    @(negedge ap_clk);
    check("t3_ready_a", 32'(req_ready), 32'h1);
    @(posedge ap_clk); #1;
    set_req(0, -8192, 2047);
    @(negedge ap_clk);
    check("t3_ready_b", 32'(req_ready), 32'h1);
    @(posedge ap_clk); #1 req_valid = 4'b0000;
    @(negedge ap_clk);
    check("t3_back2back_a", 32'(rsp_valid), 32'd1);
    @(negedge ap_clk);
    check("t3_back2back_b", 32'(rsp_valid), 32'd1);
    wait_idle("t3_drain");

    // Round robin from reset, all requesters valid
    do_reset();
    @(posedge ap_clk); #1;
    load_std_data();
    req_valid = 4'b1111;
    push_exp(0, P0); push_exp(1, P1); push_exp(2, P2);
    push_exp(3, P3); push_exp(0, P0); push_exp(1, P1);
    for (int k = 0; k < 6; k++) begin
      @(negedge ap_clk);
      check($sformatf("t4_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge ap_clk);
    end
    #1 req_valid = 4'b0000;
    @(negedge ap_clk);
    check("t4_stream", 32'(rsp_valid), 32'd1);
    wait_idle("t4_drain");

    // Backpressure: pointer sits at 2, exactly two accepts fit
    @(posedge ap_clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    push_exp(2, P2);
    push_exp(3, P3);
    acc = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      if (|(req_valid & req_ready)) acc++;
      if (c >= 2) begin
        check($sformatf("t5_hold_valid%0d", c), 32'(rsp_valid), 32'd1);
        check($sformatf("t5_hold_id%0d", c), 32'(rsp_id), 32'd2);
        check_dout($sformatf("t5_hold_dout%0d", c), rsp_dout, WO'(P2));
      end
      @(posedge ap_clk);
    end
    #1;
    check("t5_accepts", 32'(acc), 32'd2);
    check("t5_ready_zero", 32'(req_ready), 32'd0);
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    wait_idle("t5_drain");

    // Reset with two results in flight
    @(posedge ap_clk); #1;
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    repeat (2) @(posedge ap_clk);
    #1 req_valid = 4'b0000;
    check("t6_inflight", 32'(rsp_valid), 32'd1);
    #1 ap_rst_n = 1'b0;
    #1;
    check("t6_async_clear", 32'(rsp_valid), 32'd0);
    @(posedge ap_clk); #1;
    ap_rst_n  = 1'b1;
    rsp_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge ap_clk);
      if (rsp_valid) stale++;
    end
    check("t6_no_stale", 32'(stale), 32'd0);
    @(posedge ap_clk); #1;
    load_std_data();
    req_valid = 4'b1111;
    push_exp(0, P0);
    @(negedge ap_clk);
    check("t6_ptr_restart", 32'(req_ready), 32'h1);
    @(posedge ap_clk); #1 req_valid = 4'b0000;
    wait_idle("t6_drain");

    // Ten accepts for the grant counter
    do_reset();
    @(posedge ap_clk); #1;
    load_std_data();
    req_valid = 4'b1111;
    for (int k = 0; k < 10; k++) begin
      case (k % 4)
        0:       push_exp(0, P0);
        1:       push_exp(1, P1);
        2:       push_exp(2, P2);
        default: push_exp(3, P3);
      endcase
    end
    for (int k = 0; k < 10; k++) begin
      @(negedge ap_clk);
      check($sformatf("t7_grant%0d", k), 32'(req_ready), 32'(1 << (k % 4)));
      @(posedge ap_clk);
    end
    #1 req_valid = 4'b0000;
    wait_idle("t7_drain");
`ifdef CASE_1_MUL_ARB_STATS_EN
    check("t7_stat_grants", stat_grants, 32'd10);
`else
    check("t7_stat_grants", stat_grants, 32'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
